// File: rtl/cpu_sequencer.sv
// cpu_sequencer
//   Multi-cycle control sequencer for the CPU datapath. Each instruction is
//   stepped through FETCH, DECODE, EXEC (optionally MULWAIT) and WB. The
//   sequencer drives the ALU-control, register-write and PC-write enables
//   from the latched instruction word. It also counts retired legal
//   instructions.
//
//   Optional feature macro: CPU_SEQ_MUL_EN
//     defined   - R-type instructions with funct7=0000001 are handed to the
//                 iterative multiplier: mul_start_o pulses in EXEC, and the
//                 sequencer waits in MULWAIT until mul_done_i.
//     undefined - multiplies run as ordinary R-type instructions,
//                 mul_start_o is tied low and mul_done_i is ignored.
//
// Parameters
//   RETIRE_W      width of the retired-instruction counter (wraps silently)
//
// Ports
//   clk_i         system clock, rising edge
//   rst_i         synchronous active-high reset
//   start_i       run enable; sampled in IDLE and at the end of WB
//   inst_i        instruction word for the current PC, sampled in FETCH
//   mul_done_i    multiplier completion, sampled in MULWAIT only
//   ir_write_o    instruction register load strobe (FETCH)
//   alu_op_o      ALU operation class: 10 R-type, 11 I-type, 00 illegal
//   alu_src_o     0 selects rs2, 1 selects the immediate
//   reg_write_o   register file write enable (WB, legal instructions)
//   pc_write_o    PC+4 update strobe (WB)
//   mul_start_o   one-cycle multiplier start pulse (EXEC)
//   busy_o        high in every state except IDLE
//   illegal_o     one-cycle pulse in DECODE for unsupported opcodes
//   retired_o     count of legal instructions retired
module cpu_sequencer #(
    parameter int RETIRE_W = 32
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                start_i,
    input  logic [31:0]         inst_i,
    input  logic                mul_done_i,
    output logic                ir_write_o,
    output logic [1:0]          alu_op_o,
    output logic                alu_src_o,
    output logic                reg_write_o,
    output logic                pc_write_o,
    output logic                mul_start_o,
    output logic                busy_o,
    output logic                illegal_o,
    output logic [RETIRE_W-1:0] retired_o
);

    localparam logic [6:0] OPC_R = 7'b0110011;
    localparam logic [6:0] OPC_I = 7'b0010011;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MULWAIT,
        S_WB
    } state_t;

    state_t              state_q;
    logic [31:0]         ir_q;
    logic [1:0]          alu_op_q;
    logic                alu_src_q;
    logic [RETIRE_W-1:0] retired_q;
    logic                ir_legal;
    logic                ir_is_mul;
    logic                unused_bits;

    // ALU control class for an opcode, returned as {alu_op, alu_src}.
    function automatic logic [2:0] alu_ctrl(input logic [6:0] opc);
        logic [2:0] ctrl;
        ctrl = 3'b000;
        if (opc == OPC_R) begin
            ctrl = 3'b100;
        end else if (opc == OPC_I) begin
            ctrl = 3'b111;
        end
        return ctrl;
    endfunction

    assign ir_legal = (ir_q[6:0] == OPC_R) || (ir_q[6:0] == OPC_I);

`ifdef CPU_SEQ_MUL_EN
    localparam logic [6:0] F7_MUL = 7'b0000001;
    assign ir_is_mul   = (ir_q[6:0] == OPC_R) && (ir_q[31:25] == F7_MUL);
    assign mul_start_o = (state_q == S_EXEC) && ir_is_mul;
`else
    assign ir_is_mul   = 1'b0;
    assign mul_start_o = 1'b0;
`endif

    // Instruction fields other than opcode/funct7 belong to the datapath.
    assign unused_bits = ^{ir_q[31:7], mul_done_i};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            ir_q      <= '0;
            alu_op_q  <= 2'b00;
            alu_src_q <= 1'b0;
            retired_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        state_q <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    // ALU control is decoded straight from the fetched word
                    // so it is already valid during the DECODE cycle.
                    ir_q                   <= inst_i;
                    {alu_op_q, alu_src_q}  <= alu_ctrl(inst_i[6:0]);
                    state_q                <= S_DECODE;
                end
                S_DECODE: begin
                    state_q <= S_EXEC;
                end
                S_EXEC: begin
                    state_q <= ir_is_mul ? S_MULWAIT : S_WB;
                end
`ifdef CPU_SEQ_MUL_EN
                S_MULWAIT: begin
                    if (mul_done_i) begin
                        state_q <= S_WB;
                    end
                end
`endif
                S_WB: begin
                    if (ir_legal) begin
                        retired_q <= retired_q + RETIRE_W'(1);
                    end
                    state_q <= start_i ? S_FETCH : S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Strobes are pure decodes of the registered state.
    assign ir_write_o  = (state_q == S_FETCH);
    assign illegal_o   = (state_q == S_DECODE) && !ir_legal;
    assign pc_write_o  = (state_q == S_WB);
    assign reg_write_o = (state_q == S_WB) && ir_legal;
    assign busy_o      = (state_q != S_IDLE);
    assign alu_op_o    = alu_op_q;
    assign alu_src_o   = alu_src_q;
    assign retired_o   = retired_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
module tb_cpu_sequencer;

`ifdef CPU_SEQ_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        start_i = 1'b0;
    logic [31:0] inst_i = 32'h0;
    logic        mul_done_i = 1'b0;
    logic        ir_write_o;
    logic [1:0]  alu_op_o;
    logic        alu_src_o;
    logic        reg_write_o;
    logic        pc_write_o;
    logic        mul_start_o;
    logic        busy_o;
    logic        illegal_o;
    logic [31:0] retired_o;

    int checks = 0;
    int errors = 0;
    logic [31:0] model_ret = 32'h0;

    cpu_sequencer #(.RETIRE_W(32)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .start_i     (start_i),
        .inst_i      (inst_i),
        .mul_done_i  (mul_done_i),
        .ir_write_o  (ir_write_o),
        .alu_op_o    (alu_op_o),
        .alu_src_o   (alu_src_o),
        .reg_write_o (reg_write_o),
        .pc_write_o  (pc_write_o),
        .mul_start_o (mul_start_o),
        .busy_o      (busy_o),
        .illegal_o   (illegal_o),
        .retired_o   (retired_o)
    );

    always #5 clk_i = ~clk_i;

    // One instruction record: stimulus plus expected behaviour.
    // noise: 0 = mul_done low outside MULWAIT, 1 = random, 2 = held high.
    typedef struct {
        logic [31:0] inst;
        int          lat;
        int          noise;
        logic [1:0]  op;
        logic        src;
        int          len;
        logic        rw;
        logic        ill;
        logic        ms;
    } vec_t;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Behavioural reference: instruction class and length from the opcode rules.
    function automatic vec_t model(input logic [31:0] ins, input int lat);
        vec_t v;
        v.inst  = ins;
        v.lat   = lat;
        v.noise = 1;
        v.op    = 2'b00;
        v.src   = 1'b0;
        v.rw    = 1'b0;
        v.ill   = 1'b1;
        v.ms    = 1'b0;
        if (ins[6:0] == 7'h33) begin
            v.op  = 2'b10;
            v.rw  = 1'b1;
            v.ill = 1'b0;
            v.ms  = MUL_EN && (ins[31:25] == 7'h01);
        end else if (ins[6:0] == 7'h13) begin
            v.op  = 2'b11;
            v.src = 1'b1;
            v.rw  = 1'b1;
            v.ill = 1'b0;
        end
        v.len = v.ms ? 4 + lat : 4;
        return v;
    endfunction

    // Entered at cycle 1 (FETCH) of an instruction; returns in its WB cycle.
    task automatic run_check(input vec_t v, input string tag);
        int wb_c = 0;
        int ir_c = 0;
        int n_ir = 0;
        int ill_c = 0;
        int n_ill = 0;
        int ms_c = 0;
        int n_ms = 0;
        logic [1:0] op2 = 2'b00;
        logic src2 = 1'b0;
        logic busy_ok = 1'b1;
        logic rw = 1'b0;
        logic [1:0] op_wb = 2'b00;
        inst_i = v.inst;
        for (int c = 1; c <= 40; c++) begin
            if (ir_write_o) begin n_ir++; ir_c = c; end
            if (illegal_o) begin n_ill++; ill_c = c; end
            if (!busy_o) busy_ok = 1'b0;
            if (c == 2) begin op2 = alu_op_o; src2 = alu_src_o; end
            if (ms_c != 0) mul_done_i = (c == ms_c + v.lat);
            else if (v.noise == 2) mul_done_i = 1'b1;
            else if (v.noise == 1) mul_done_i = 1'($urandom_range(0, 1));
            else mul_done_i = 1'b0;
            if (mul_start_o) begin n_ms++; ms_c = c; end
            if (pc_write_o) begin
                wb_c = c;
                rw = reg_write_o;
                op_wb = alu_op_o;
                break;
            end
            tick();
        end
        mul_done_i = 1'b0;
        check({tag, ".wb_cycle"}, wb_c, v.len);
        check({tag, ".reg_write"}, rw, v.rw);
        check({tag, ".ir_write_count"}, n_ir, 1);
        check({tag, ".ir_write_cycle"}, ir_c, 1);
        check({tag, ".illegal_count"}, n_ill, v.ill);
        check({tag, ".illegal_cycle"}, ill_c, v.ill ? 2 : 0);
        check({tag, ".mul_start_count"}, n_ms, v.ms);
        check({tag, ".mul_start_cycle"}, ms_c, v.ms ? 3 : 0);
        check({tag, ".alu_op_c2"}, op2, v.op);
        check({tag, ".alu_src_c2"}, src2, v.src);
        check({tag, ".alu_op_wb"}, op_wb, v.op);
        check({tag, ".busy"}, busy_ok, 1'b1);
    endtask

    task automatic apply(input vec_t v, input string tag, input bit last);
        run_check(v, tag);
        if (last) start_i = 1'b0;
        tick();
        if (v.rw) model_ret = model_ret + 32'd1;
        check({tag, ".retired"}, retired_o, model_ret);
        if (last) check({tag, ".busy_after"}, busy_o, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        vec_t vecs[8];
        vecs[0] = '{32'h00500093, 0, 0, 2'b11, 1'b1, 4, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{32'h002081B3, 0, 0, 2'b10, 1'b0, 4, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{32'h002081B3, 0, 1, 2'b10, 1'b0, 4, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{32'h002081B3, 0, 0, 2'b10, 1'b0, 4, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{32'h022081B3, 3, 2, 2'b10, 1'b0, MUL_EN ? 7 : 4, 1'b1, 1'b0, MUL_EN};
        vecs[5] = '{32'h0000007F, 0, 0, 2'b00, 1'b0, 4, 1'b0, 1'b1, 1'b0};
        vecs[6] = '{32'h022081B3, 1, 0, 2'b10, 1'b0, MUL_EN ? 5 : 4, 1'b1, 1'b0, MUL_EN};
        vecs[7] = '{32'h02500093, 2, 2, 2'b11, 1'b1, 4, 1'b1, 1'b0, 1'b0};

        // Reset state
        tick();
        tick();
        check("rst.busy", busy_o, 1'b0);
        check("rst.ir_write", ir_write_o, 1'b0);
        check("rst.alu_op", alu_op_o, 2'b00);
        check("rst.alu_src", alu_src_o, 1'b0);
        check("rst.reg_write", reg_write_o, 1'b0);
        check("rst.pc_write", pc_write_o, 1'b0);
        check("rst.mul_start", mul_start_o, 1'b0);
        check("rst.illegal", illegal_o, 1'b0);
        check("rst.retired", retired_o, 32'h0);
        rst_i = 1'b0;
        tick();
        tick();
        check("idle.busy", busy_o, 1'b0);

        // Directed table, back-to-back with start held
        start_i = 1'b1;
        tick();
        for (int i = 0; i < 8; i++) begin
            apply(vecs[i], $sformatf("vec%0d", i), i == 7);
        end

        // start_i dropped during EXEC: instruction completes, then IDLE
        start_i = 1'b1;
        inst_i = 32'h002081B3;
        tick();
        check("drop.fetch", ir_write_o, 1'b1);
        tick();
        tick();
        start_i = 1'b0;
        tick();
        check("drop.pc_write", pc_write_o, 1'b1);
        check("drop.reg_write", reg_write_o, 1'b1);
        tick();
        model_ret = model_ret + 32'd1;
        check("drop.retired", retired_o, model_ret);
        check("drop.busy", busy_o, 1'b0);
        tick();
        check("drop.stay_idle", ir_write_o | busy_o, 1'b0);

        // Reset mid-instruction (MULWAIT when multiply is built in)
        start_i = 1'b1;
        inst_i = 32'h022081B3;
        tick();
        for (int c = 1; c < (MUL_EN ? 4 : 3); c++) tick();
        check("midrst.busy_before", busy_o, 1'b1);
        check("midrst.pc_write_before", pc_write_o, 1'b0);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        start_i = 1'b0;
        check("midrst.busy", busy_o, 1'b0);
        check("midrst.pc_write", pc_write_o, 1'b0);
        check("midrst.reg_write", reg_write_o, 1'b0);
        check("midrst.retired", retired_o, 32'h0);
        check("midrst.alu_op", alu_op_o, 2'b00);
        model_ret = 32'h0;
        tick();
        check("midrst.next_strobes", {pc_write_o, reg_write_o, busy_o}, 3'b000);

        // Randomized instruction stream against the reference model
        start_i = 1'b1;
        tick();
        for (int i = 0; i < 40; i++) begin
            logic [31:0] r;
            logic [31:0] ins;
            int k;
            r = $urandom;
            k = $urandom_range(0, 3);
            case (k)
                0: ins = {r[31:7], 7'h33};
                1: ins = {7'h01, r[24:7], 7'h33};
                2: ins = {r[31:7], 7'h13};
                default: ins = r;
            endcase
            apply(model(ins, $urandom_range(1, 6)), $sformatf("rnd%0d", i), i == 39);
        end

        // Counter wrap
        force dut.retired_q = 32'hFFFF_FFFF;
        #1;
        release dut.retired_q;
        model_ret = 32'hFFFF_FFFF;
        start_i = 1'b1;
        tick();
        apply(vecs[0], "wrap", 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cpu_sequencer.md
# cpu_sequencer

Multi-cycle control sequencer for the CPU datapath. It steps each instruction through fetch, decode, execute and write-back, and drives the datapath's ALU-control, register-write and PC-write enables from the latched instruction word. With the multiply extension compiled in, it hands multiply instructions to the iterative multiplier and waits for its completion handshake. It also counts retired instructions for the testbench and for performance reporting.

## Interface
- RETIRE_W, default 32: width of the retired-instruction counter.

- clk_i, input, 1: system clock; all state updates on the rising edge.
- rst_i, input, 1: reset, synchronous, active-high.
- start_i, input, 1: run enable; the CPU executes while high.
- inst_i, input, 32: instruction word from the instruction memory for the current PC; sampled only in FETCH.
- mul_done_i, input, 1: multiplier completion; sampled only in MULWAIT.
- ir_write_o, output, 1: instruction register load strobe.
- alu_op_o, output, 2: ALU operation class to ALU control.
- alu_src_o, output, 1: 0 selects register rs2, 1 selects the immediate.
- reg_write_o, output, 1: register file write enable.
- pc_write_o, output, 1: PC update strobe (PC+4).
- mul_start_o, output, 1: one-cycle multiplier start pulse.
- busy_o, output, 1: high in every state except IDLE.
- illegal_o, output, 1: one-cycle pulse when an unsupported opcode is decoded.
- retired_o, output, RETIRE_W: count of legal instructions retired.

## Operation
- State machine: IDLE, FETCH, DECODE, EXEC, MULWAIT, WB.
- Internal instruction register (IR): loaded from inst_i at the FETCH edge.

- **IDLE**
  - All strobes low.
  - start_i=1 -> FETCH.
- **FETCH**
  - ir_write_o=1.
  - Always -> DECODE.
- **DECODE** (classifies IR[6:0])
  - 0110011, R-type: alu_op=2'b10, alu_src=0.
  - 0010011, I-type: alu_op=2'b11, alu_src=1.
  - Any other opcode is illegal: alu_op=2'b00, alu_src=0, illegal_o pulses in this cycle.
  - Always -> EXEC.
- alu_op_o and alu_src_o are registered at the DECODE edge and held until the next DECODE.
- **EXEC**
  - IR is a multiply (R-type, IR[31:25]=7'b0000001): mul_start_o=1 and -> MULWAIT.
  - Otherwise -> WB.
- **MULWAIT**
  - Stays while mul_done_i=0.
  - mul_done_i=1 -> WB.
  - No timeout.
- **WB**
  - pc_write_o=1.
  - reg_write_o=1 for legal instructions only.
  - retired_o increments for legal instructions only.
  - start_i=1 -> FETCH; start_i=0 -> IDLE.
- Illegal instruction: treated as a NOP. PC advances, no register write, no retire count.
- retired_o wraps from 2^RETIRE_W-1 to 0 with no flag.
- start_i falling mid-instruction: the current instruction completes through WB, then the sequencer goes to IDLE.

## Timing
- Reset: at the reset edge, state=IDLE, IR=0, retired_o=0.
  - alu_op_o=2'b00.
  - alu_src_o, reg_write_o, pc_write_o, ir_write_o, mul_start_o, busy_o and illegal_o are all 0.
- Reset asserted in any state, including MULWAIT, forces IDLE on that edge. An in-flight instruction is abandoned with no WB strobes.
- Strobes (ir_write_o, illegal_o, mul_start_o, reg_write_o, pc_write_o) are decoded from the registered state. Each is high for exactly the one cycle its state is held.
- Non-multiply instruction: 4 cycles, FETCH through WB. With start_i held high, back-to-back instructions give one WB every 4 cycles.
- Multiply instruction: 4 + N cycles, where N >= 1 is the number of MULWAIT cycles.
  - The minimum of 5 cycles occurs when mul_done_i is high in the first MULWAIT cycle.
  - mul_done_i high during EXEC or any other state is ignored.
- First FETCH occurs the cycle after start_i is sampled high in IDLE.

## Configuration
- CPU_SEQ_MUL_EN defined:
  - Multiply decode is active and MULWAIT is reachable.
  - mul_start_o and mul_done_i behave as specified.
- CPU_SEQ_MUL_EN undefined:
  - funct7=7'b0000001 R-type instructions run as ordinary 4-cycle R-type instructions.
  - mul_start_o is tied 0 and mul_done_i is unused.
  - MULWAIT is unreachable and may be removed.

## Test plan
- Reset, then start_i=1 with inst_i=ADDI (0x00500093) -> ir_write_o in cycle 1; alu_op_o=2'b11 and alu_src_o=1 from cycle 2; reg_write_o and pc_write_o in cycle 4; retired_o=1.
- Three back-to-back ADD instructions (0x002081B3) with start_i held -> WB every 4 cycles; alu_op_o=2'b10, alu_src_o=0; retired_o=3.
- MUL (0x022081B3) with mul_done_i returned 3 cycles after mul_start_o -> 7-cycle instruction; exactly one mul_start_o pulse; reg_write_o only after done. Without the macro -> same MUL completes in 4 cycles and mul_start_o never asserts.
- Opcode 0x7F -> illegal_o pulses once in DECODE; pc_write_o=1 and reg_write_o=0 in WB; retired_o unchanged.
- start_i dropped during EXEC -> that instruction completes WB, then IDLE with busy_o=0. rst_i asserted in MULWAIT -> IDLE, retired_o=0, no WB strobes on the next cycle.
- Preload retired_o to 2^32-1 via force, then retire one instruction -> retired_o=0.
